// File: rtl/card_hand_renderer_if.sv
// VGA timing/colour bundle carried through the video pipeline layers.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/card_hand_renderer.sv
// Renders a hand of overlapping cards over the incoming VGA stream; new cards
// slide in from the deck position, one at a time, advancing once per frame.
module card_hand_renderer #(
  parameter int          NUM_CARDS   = 9,
  parameter int          HAND_XPOS   = 437,
  parameter int          HAND_YPOS   = 550,
  parameter int          SPACING     = 30,
  parameter int          CARD_W      = 32,
  parameter int          CARD_H      = 48,
  parameter int          DECK_XPOS   = 900,
  parameter int          DECK_YPOS   = 350,
  parameter int          ANIM_SHIFT  = 3,
  parameter logic [11:0] TRANSPARENT = 12'h0F0,
  parameter logic [5:0]  BACK_CODE   = 6'h3F
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_if.in                      vga_in,
  vga_if.out                     vga_out,
  input  logic [3:0]             card_count,
  input  logic [NUM_CARDS*6-1:0] card_codes,
  input  logic                   hide_hole,
  output logic [10:0]            rom_addr,
  output logic [5:0]             rom_code,
  input  logic [11:0]            rom_rgb,
  output logic [3:0]             shown_count,
  output logic                   busy
);

  localparam int KW = ANIM_SHIFT + 1;
  localparam logic [KW-1:0]     K_END  = KW'(2 ** ANIM_SHIFT);
  localparam logic signed [12:0] DECK_X = 13'(DECK_XPOS);
  localparam logic signed [12:0] DECK_Y = 13'(DECK_YPOS);

  typedef enum logic {IDLE, ANIM} state_t;

  state_t                state, state_nxt;
  logic [KW-1:0]         k, k_nxt, k_inc;
  logic signed [12:0]    anim_x, anim_y, anim_x_nxt, anim_y_nxt;
  logic [3:0]            shown_nxt;
  logic                  vblnk_q, tick, abort;
  logic signed [12:0]    dst_x, dst_y;

  // Position k/2^ANIM_SHIFT of the way from the deck to the destination,
  // rounded toward minus infinity by the arithmetic shift.
  function automatic logic signed [12:0] lerp(input logic signed [12:0] from,
                                              input logic signed [12:0] to,
                                              input logic [KW-1:0] kk);
    logic signed [12:0] prod;
    prod = (to - from) * $signed(13'(kk));
    return from + (prod >>> ANIM_SHIFT);
  endfunction

  assign tick  = vga_in.vblnk & ~vblnk_q;
  assign busy  = (state == ANIM);
  assign k_inc = k + 1'b1;
  assign dst_x = 13'(HAND_XPOS + int'(shown_count) * SPACING);
  assign dst_y = 13'(HAND_YPOS);
  assign abort = ({1'b0, card_count} < ({1'b0, shown_count} + {4'b0, busy}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      anim_x      <= DECK_X;
      anim_y      <= DECK_Y;
      shown_count <= '0;
      vblnk_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      anim_x      <= anim_x_nxt;
      anim_y      <= anim_y_nxt;
      shown_count <= shown_nxt;
      vblnk_q     <= vga_in.vblnk;
    end
  end

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    anim_x_nxt = anim_x;
    anim_y_nxt = anim_y;
    shown_nxt  = shown_count;
    if (abort) begin
      state_nxt  = IDLE;
      shown_nxt  = card_count;
      k_nxt      = '0;
      anim_x_nxt = DECK_X;
      anim_y_nxt = DECK_Y;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          if ((card_count > shown_count) && (int'(shown_count) < NUM_CARDS)) begin
            state_nxt  = ANIM;
            k_nxt      = '0;
            anim_x_nxt = DECK_X;
            anim_y_nxt = DECK_Y;
          end
        end
        ANIM: begin
          if (k_inc == K_END) begin
            state_nxt  = IDLE;
            shown_nxt  = shown_count + 4'd1;
            k_nxt      = '0;
            anim_x_nxt = DECK_X;
            anim_y_nxt = DECK_Y;
          end else begin
            k_nxt      = k_inc;
            anim_x_nxt = lerp(DECK_X, dst_x, k_inc);
            anim_y_nxt = lerp(DECK_Y, dst_y, k_inc);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage 1: hit test; walking upward lets the highest-index card win.
  logic        hit_c, hit1;
  logic [10:0] addr_c;
  logic [5:0]  code_c;

  always_comb begin
    logic signed [12:0] h, v, sx, sy, col, row;
    logic               live;
    hit_c  = 1'b0;
    addr_c = '0;
    code_c = '0;
    h = $signed({2'b00, vga_in.hcount});
    v = $signed({2'b00, vga_in.vcount});
    for (int unsigned i = 0; i < NUM_CARDS; i++) begin
      live = (i < 32'(shown_count)) || ((i == 32'(shown_count)) && busy);
      if (i == 32'(shown_count)) begin
        sx = anim_x;
        sy = anim_y;
      end else begin
        sx = 13'(HAND_XPOS + int'(i) * SPACING);
        sy = 13'(HAND_YPOS);
      end
      col = h - sx;
      row = v - sy;
      if (live && (col >= 13'sd0) && (col < 13'(CARD_W)) &&
          (row >= 13'sd0) && (row < 13'(CARD_H))) begin
        hit_c  = 1'b1;
        addr_c = 11'(row * 13'(CARD_W) + col);
        code_c = ((i == 1) && hide_hole) ? BACK_CODE : card_codes[6*i +: 6];
      end
    end
    if (vga_in.hblnk | vga_in.vblnk) hit_c = 1'b0;
  end

  logic [10:0] hc1, vc1;
  logic        hs1, vs1, hb1, vb1;
  logic [11:0] rgb1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      rom_code <= '0;
      hit1     <= 1'b0;
      hc1      <= '0;
      vc1      <= '0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      hb1      <= 1'b0;
      vb1      <= 1'b0;
      rgb1     <= '0;
    end else begin
      rom_addr <= addr_c;
      rom_code <= code_c;
      hit1     <= hit_c;
      hc1      <= vga_in.hcount;
      vc1      <= vga_in.vcount;
      hs1      <= vga_in.hsync;
      vs1      <= vga_in.vsync;
      hb1      <= vga_in.hblnk;
      vb1      <= vga_in.vblnk;
      rgb1     <= vga_in.rgb;
    end
  end

  // Stage 2: overlay ROM colour unless it is the see-through key.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= hc1;
      vga_out.vcount <= vc1;
      vga_out.hsync  <= hs1;
      vga_out.vsync  <= vs1;
      vga_out.hblnk  <= hb1;
      vga_out.vblnk  <= vb1;
      vga_out.rgb    <= (hit1 && (rom_rgb != TRANSPARENT)) ? rom_rgb : rgb1;
    end
  end

endmodule

// File: tb/tb_card_hand_renderer.sv
// Randomized bench for card_hand_renderer against a frame-level hand model.
module tb_card_hand_renderer;
  localparam int NC = 9, HX = 437, HY = 550, SP = 30, CW = 32, CH = 48;
  localparam int DX = 900, DY = 350, AS = 3;
  localparam logic [11:0] TR = 12'h0F0;
  localparam logic [5:0]  BC = 6'h3F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3:0]      card_count;
  logic [NC*6-1:0] card_codes;
  logic            hide_hole;
  logic [10:0]     rom_addr;
  logic [5:0]      rom_code;
  logic [11:0]     rom_rgb;
  logic [3:0]      shown_count;
  logic            busy;

  vga_if vin();
  vga_if vout();

  card_hand_renderer #(
    .NUM_CARDS(NC), .HAND_XPOS(HX), .HAND_YPOS(HY), .SPACING(SP),
    .CARD_W(CW), .CARD_H(CH), .DECK_XPOS(DX), .DECK_YPOS(DY),
    .ANIM_SHIFT(AS), .TRANSPARENT(TR), .BACK_CODE(BC)
  ) dut (
    .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout),
    .card_count(card_count), .card_codes(card_codes), .hide_hole(hide_hole),
    .rom_addr(rom_addr), .rom_code(rom_code), .rom_rgb(rom_rgb),
    .shown_count(shown_count), .busy(busy)
  );

  function automatic logic [11:0] rom_model(input logic [5:0] code, input logic [10:0] addr);
    if (addr % 7 == 3) return TR;
    return {code, addr[5:0]};
  endfunction

  assign rom_rgb = rom_model(rom_code, rom_addr);

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand model: cards shown, whether one is sliding, and its frame index.
  int m_shown = 0, m_k = 0;
  bit m_busy  = 1'b0;

  function automatic int fdiv(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic logic [5:0] slot_code(input int i);
    return card_codes[6*i +: 6];
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v, input bit blank,
                                          input logic [11:0] bg, input bit hide);
    int sx, sy, n;
    logic [5:0]  code;
    logic [11:0] r;
    if (blank) return bg;
    n = m_busy ? m_shown + 1 : m_shown;
    for (int i = n - 1; i >= 0; i--) begin
      if (m_busy && i == m_shown) begin
        sx = DX + fdiv((HX + m_shown * SP - DX) * m_k, 2 ** AS);
        sy = DY + fdiv((HY - DY) * m_k, 2 ** AS);
      end else begin
        sx = HX + i * SP;
        sy = HY;
      end
      if (h >= sx && h < sx + CW && v >= sy && v < sy + CH) begin
        code = (i == 1 && hide) ? BC : slot_code(i);
        r = rom_model(code, 11'((v - sy) * CW + (h - sx)));
        return (r == TR) ? bg : r;
      end
    end
    return bg;
  endfunction

  task automatic drive_pix(input int h, input int v, input bit hb, input logic [11:0] c);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = 1'b0;
    vin.hsync  = 1'($urandom_range(0, 1));
    vin.vsync  = 1'($urandom_range(0, 1));
    vin.rgb    = c;
  endtask

  task automatic tick_frame();
    @(negedge clk);
    vin.vblnk = 1'b1;
    vin.hblnk = 1'b1;
    @(negedge clk);
    vin.vblnk = 1'b0;
    vin.hblnk = 1'b0;
    if (m_busy) begin
      m_k++;
      if (m_k == 2 ** AS) begin
        m_shown++;
        m_busy = 1'b0;
        m_k    = 0;
      end
    end else if (int'(card_count) > m_shown && m_shown < NC) begin
      m_busy = 1'b1;
      m_k    = 0;
    end
    check("tick_shown", 64'(shown_count), 64'(m_shown));
    check("tick_busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic set_count(input int n);
    @(negedge clk);
    card_count = 4'(n);
    if (n < m_shown + int'(m_busy)) begin
      m_shown = n;
      m_busy  = 1'b0;
      m_k     = 0;
    end
    @(negedge clk);
    check("cnt_shown", 64'(shown_count), 64'(m_shown));
    check("cnt_busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic probe(input int n);
    logic [37:0] q[$];
    logic [37:0] e;
    int h, v;
    bit hb, hide;
    logic [11:0] bg;
    for (int j = 0; j < n + 2; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        e = q.pop_front();
        check("pix", {26'b0, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                      vout.hblnk, vout.vblnk, vout.rgb}, {26'b0, e});
      end
      if (j < n) begin
        h    = $urandom_range(380, 960);
        v    = $urandom_range(330, 620);
        hb   = ($urandom_range(0, 9) == 0);
        bg   = 12'($urandom);
        hide = 1'($urandom_range(0, 1));
        hide_hole = hide;
        drive_pix(h, v, hb, bg);
        q.push_back({11'(h), 11'(v), vin.hsync, vin.vsync, hb, 1'b0,
                     exp_rgb(h, v, hb, bg, hide)});
      end
    end
    hide_hole = 1'b0;
  endtask

  task automatic pix_at(input string tag, input int h, input int v, input logic [11:0] exp);
    @(negedge clk);
    drive_pix(h, v, 1'b0, 12'h5A5);
    @(negedge clk);
    @(negedge clk);
    check(tag, 64'(vout.rgb), 64'(exp));
  endtask

  initial begin
    rst        = 1'b1;
    card_count = '0;
    hide_hole  = 1'b0;
    for (int i = 0; i < NC; i++) card_codes[6*i +: 6] = 6'($urandom_range(0, 62));
    card_codes[11:6] = 6'h05;
    vin.hcount = 11'd100; vin.vcount = 11'd100;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.rgb = 12'h123;

    repeat (3) @(negedge clk);
    check("rst_rgb", 64'(vout.rgb), 64'h0);
    check("rst_shown", 64'(shown_count), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_addr", 64'(rom_addr), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_1cyc", 64'(vout.rgb), 64'h0);
    @(negedge clk);
    check("rel_2cyc", 64'(vout.rgb), 64'h123);

    // Two static cards.
    set_count(2);
    repeat (2 * 9 + 2) tick_frame();
    check("static_shown", 64'(shown_count), 64'd2);
    pix_at("overlap_slot1", 470, 560, {slot_code(1), 6'(323)});
    pix_at("left_of_hand", 436, 560, 12'h5A5);
    pix_at("transparent", 472, 560, 12'h5A5);
    probe(200);

    // Single animated card.
    set_count(0);
    set_count(1);
    tick_frame();
    check("anim_busy_rise", 64'(busy), 64'd1);
    repeat (4) tick_frame();
    pix_at("anim_corner", 668, 450, {slot_code(0), 6'd0});
    pix_at("anim_left", 667, 450, 12'h5A5);
    pix_at("anim_above", 668, 449, 12'h5A5);
    probe(100);
    repeat (4) tick_frame();
    check("anim_done_shown", 64'(shown_count), 64'd1);
    check("anim_done_busy", 64'(busy), 64'd0);
    pix_at("anim_placed", 437, 550, {slot_code(0), 6'd0});

    // Queue past the slot limit.
    set_count(10);
    for (int t = 0; t < 9 * 9 + 5; t++) begin
      tick_frame();
      if (t % 6 == 0) probe(20);
    end
    check("sat_shown", 64'(shown_count), 64'd9);
    check("sat_busy", 64'(busy), 64'd0);
    repeat (3) tick_frame();

    // Abort while slot 3 is sliding.
    set_count(0);
    set_count(5);
    for (int t = 0; t < 100 && !(m_shown == 3 && m_busy && m_k == 2); t++) tick_frame();
    check("abort_setup", 64'(m_shown == 3 && m_busy && m_k == 2), 64'd1);
    set_count(0);
    check("abort_shown", 64'(shown_count), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    probe(100);

    // Hole card.
    set_count(2);
    repeat (20) tick_frame();
    @(negedge clk);
    hide_hole = 1'b1;
    drive_pix(470, 560, 1'b0, 12'h5A5);
    @(negedge clk);
    check("hole_back", 64'(rom_code), 64'(BC));
    hide_hole = 1'b0;
    @(negedge clk);
    check("hole_face", 64'(rom_code), 64'h05);
    probe(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
